vbus_frame_checker: RTL and testbench

Video-bus frame-format checker and register slice placed between `parallel_2_vbus` and `median_filter`. It forwards VBUS beats with one cycle of latency through a 2-entry skid buffer. While forwarding, it counts columns and rows from the aux framing flags against the configured WIDTH/HEIGHT, drops stray beats that arrive before start-of-frame, and records sticky protocol errors. Configuration and status are accessed through the same memory-bus style used by the filter.

---
 rtl/vbus_frame_checker_if.sv | 14 +
 rtl/vbus_frame_checker.sv | 218 +++++++++++++++++++++
 tb/tb_vbus_frame_checker.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vbus_frame_checker_if.sv
// Video-bus beat channel: valid/ready handshake carrying aux framing flags and pixel data.
// A beat transfers on a clock edge where val and rdy are both high; the sender holds aux/dat while val waits for rdy.
interface vbus_frame_checker_if #(
    parameter int DW_VD = 8,
    parameter int DW_VX = 4
) ();
    logic             val;
    logic             rdy;
    logic [DW_VX-1:0] aux;
    logic [DW_VD-1:0] dat;

    modport master (output val, output aux, output dat, input rdy);
    modport slave  (input val, input aux, input dat, output rdy);
endinterface

// File: rtl/vbus_frame_checker.sv
// VBUS frame-format checker: 2-entry skid-buffered register slice that counts columns/rows
// against WIDTH/HEIGHT, drops beats seen before start-of-frame and keeps sticky error flags.
module vbus_frame_checker #(
    parameter int          DW_VD      = 8,
    parameter int          DW_VX      = 4,
    parameter int          DW_MA      = 8,
    parameter int          DW_MD      = 16,
    parameter int unsigned DEF_WIDTH  = 640,
    parameter int unsigned DEF_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rstb,
    vbus_frame_checker_if.slave  s_vb,
    vbus_frame_checker_if.master m_vb,
    input  logic [DW_MA-1:0]     s_mb_adr,
    input  logic [DW_MD-1:0]     s_mb_wdt,
    input  logic                 s_mb_val,
    output logic [DW_MD-1:0]     s_mb_rdt,
    output logic                 error,
    output logic                 dbg_state
);

    localparam int BW = DW_VX + DW_VD;
    localparam logic [DW_MA-1:0] A_CTRL   = DW_MA'(0);
    localparam logic [DW_MA-1:0] A_WIDTH  = DW_MA'(1);
    localparam logic [DW_MA-1:0] A_HEIGHT = DW_MA'(2);
    localparam logic [DW_MA-1:0] A_STATUS = DW_MA'(3);
    localparam logic [DW_MA-1:0] A_FCNT   = DW_MA'(4);
    localparam logic [DW_MD-1:0] ONE      = DW_MD'(1);
    localparam logic [DW_MD-1:0] CNT_MAX  = '1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // ---------------- skid buffer ----------------
    logic [BW-1:0] buf_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          rdy_q;
    logic          accept, push, pop;

    assign accept   = s_vb.val & rdy_q;
    assign s_vb.rdy = rdy_q;
    assign m_vb.val = (cnt_q != 2'd0);
    assign pop      = m_vb.val & m_vb.rdy;
    assign {m_vb.aux, m_vb.dat} = buf_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Ready is registered from the post-edge occupancy, so a full buffer never sees a push.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= {s_vb.aux, s_vb.dat};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
        end
    end

    // ---------------- registers ----------------
    logic             en_q;
    logic [DW_MD-1:0] width_q, height_q, fcnt_q, fcnt_d;
    logic [4:0]       sts_q, sts_d, sts_set, sts_clr;
    logic             fcnt_inc;
    logic             wr_ctrl, wr_width, wr_height, wr_sts, wr_fcnt;
    logic [DW_MD-1:0] rd_d;

    assign wr_ctrl   = s_mb_val && (s_mb_adr == A_CTRL);
    assign wr_width  = s_mb_val && (s_mb_adr == A_WIDTH);
    assign wr_height = s_mb_val && (s_mb_adr == A_HEIGHT);
    assign wr_sts    = s_mb_val && (s_mb_adr == A_STATUS);
    assign wr_fcnt   = s_mb_val && (s_mb_adr == A_FCNT);

    // A hardware set on the same edge as a software clear keeps the bit set.
    assign sts_clr = wr_sts ? s_mb_wdt[4:0] : 5'd0;
    assign sts_d   = (sts_q & ~sts_clr) | sts_set;
    assign fcnt_d  = (wr_fcnt ? '0 : fcnt_q) + (fcnt_inc ? ONE : '0);
    assign error   = |sts_q;

    always_comb begin
        rd_d = '0;
        case (s_mb_adr)
            A_CTRL:   rd_d = {{(DW_MD-1){1'b0}}, en_q};
            A_WIDTH:  rd_d = width_q;
            A_HEIGHT: rd_d = height_q;
            A_STATUS: rd_d = {{(DW_MD-5){1'b0}}, sts_q};
            A_FCNT:   rd_d = fcnt_q;
            default:  rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            en_q     <= 1'b0;
            width_q  <= DW_MD'(DEF_WIDTH);
            height_q <= DW_MD'(DEF_HEIGHT);
            sts_q    <= 5'd0;
            fcnt_q   <= '0;
            s_mb_rdt <= '0;
        end else begin
            if (wr_ctrl)   en_q     <= s_mb_wdt[0];
            if (wr_width)  width_q  <= s_mb_wdt;
            if (wr_height) height_q <= s_mb_wdt;
            sts_q    <= sts_d;
            fcnt_q   <= fcnt_d;
            s_mb_rdt <= rd_d;
        end
    end

    // ---------------- frame checker ----------------
    logic             sof, eol, eof;
    logic [DW_MD-1:0] col_q, col_d, row_q, row_d;
    logic [DW_MD-1:0] wm1, hm1, c, r;
    logic             long_q, long_d, lng;

    assign sof = s_vb.aux[0];
    assign eol = s_vb.aux[1];
    assign eof = s_vb.aux[2];
    assign wm1 = width_q - ONE;
    assign hm1 = height_q - ONE;

    assign dbg_state = (state_q == ST_ACTIVE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            long_q  <= long_d;
        end
    end

    // c/r/lng are the counters as seen by this beat after any SOF restart has been applied.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        long_d   = long_q;
        sts_set  = 5'd0;
        push     = 1'b0;
        fcnt_inc = 1'b0;
        c        = col_q;
        r        = row_q;
        lng      = long_q;
        if (!en_q) begin
            state_d = ST_IDLE;
            col_d   = '0;
            row_d   = '0;
            long_d  = 1'b0;
            push    = accept;
        end else if (accept) begin
            if (state_q == ST_IDLE && !sof) begin
                sts_set[0] = 1'b1;
            end else begin
                push    = 1'b1;
                state_d = ST_ACTIVE;
                if (sof) begin
                    sts_set[4] = (state_q == ST_ACTIVE);
                    c   = '0;
                    r   = '0;
                    lng = 1'b0;
                end
                if (eol) begin
                    if (c < wm1) sts_set[1] = 1'b1;
                    if (c > wm1) sts_set[2] = 1'b1;
                    col_d  = '0;
                    row_d  = (r == CNT_MAX) ? r : r + ONE;
                    long_d = 1'b0;
                end else begin
                    col_d  = (c == CNT_MAX) ? c : c + ONE;
                    row_d  = r;
                    long_d = lng;
                    if (c >= width_q && !lng) begin
                        sts_set[2] = 1'b1;
                        long_d     = 1'b1;
                    end
                end
                if (eof) begin
                    if (r != hm1 || !eol) sts_set[3] = 1'b1;
                    fcnt_inc = 1'b1;
                    state_d  = ST_IDLE;
                    col_d    = '0;
                    row_d    = '0;
                    long_d   = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vbus_frame_checker.sv
// Self-checking bench for vbus_frame_checker: scoreboard of forwarded beats plus register readback checks.
module tb_vbus_frame_checker;

    localparam int BW = 12;

    logic        clk;
    logic        rstb;
    logic [7:0]  s_mb_adr;
    logic [15:0] s_mb_wdt;
    logic        s_mb_val;
    logic [15:0] s_mb_rdt;
    logic        error;
    logic        dbg_state;

    vbus_frame_checker_if #(.DW_VD(8), .DW_VX(4)) s_vb ();
    vbus_frame_checker_if #(.DW_VD(8), .DW_VX(4)) m_vb ();

    vbus_frame_checker #(
        .DW_VD(8), .DW_VX(4), .DW_MA(8), .DW_MD(16), .DEF_WIDTH(640), .DEF_HEIGHT(480)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .s_vb      (s_vb),
        .m_vb      (m_vb),
        .s_mb_adr  (s_mb_adr),
        .s_mb_wdt  (s_mb_wdt),
        .s_mb_val  (s_mb_val),
        .s_mb_rdt  (s_mb_rdt),
        .error     (error),
        .dbg_state (dbg_state)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [BW-1:0] exp_q[$];
    logic          cur_fwd;
    int            bp_mode;
    int            occ;
    bit            armed;
    bit            prev_stall;
    logic [BW:0]   held;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       m_vb.rdy = 1'b1;
            1:       m_vb.rdy = ~m_vb.rdy;
            default: m_vb.rdy = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            occ        = 0;
            armed      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (armed) check("s_rdy", 32'(s_vb.rdy), 32'(occ < 2));
            armed = 1'b1;
            if (prev_stall) check("stall_hold", 32'({m_vb.val, m_vb.aux, m_vb.dat}), 32'(held));
            prev_stall = m_vb.val && !m_vb.rdy;
            held       = {1'b1, m_vb.aux, m_vb.dat};
            if (m_vb.val && m_vb.rdy) begin
                check("m_beat_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) check("m_beat", 32'({m_vb.aux, m_vb.dat}), 32'(exp_q.pop_front()));
                occ--;
            end
            if (s_vb.val && s_vb.rdy && cur_fwd) begin
                exp_q.push_back({s_vb.aux, s_vb.dat});
                occ++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [3:0] aux, input logic [7:0] dat, input logic fwd);
        bit acc = 1'b0;
        s_vb.val = 1'b1;
        s_vb.aux = aux;
        s_vb.dat = dat;
        cur_fwd  = fwd;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            if (s_vb.rdy) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_vb.val = 1'b0;
        cur_fwd  = 1'b0;
        check("beat_accepted", 32'(acc), 32'(1));
    endtask

    task automatic send_frame(input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                logic [3:0] a;
                a[0] = (r == 0 && c == 0);
                a[1] = (c == w - 1);
                a[2] = (r == h - 1 && c == w - 1);
                a[3] = 1'($urandom_range(0, 1));
                send_beat(a, 8'($urandom_range(0, 255)), 1'b1);
            end
        end
    endtask

    task automatic mb_write(input logic [7:0] adr, input logic [15:0] data);
        s_mb_adr = adr;
        s_mb_wdt = data;
        s_mb_val = 1'b1;
        @(posedge clk);
        #1;
        s_mb_val = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [7:0] adr, input logic [15:0] exp);
        s_mb_adr = adr;
        @(posedge clk);
        #1;
        check(tag, 32'(s_mb_rdt), 32'(exp));
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_vb.val) break;
        end
        @(posedge clk);
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'(0));
        check("drain_mval", 32'(m_vb.val), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstb     = 1'b0;
        s_vb.val = 1'b0;
        s_vb.aux = '0;
        s_vb.dat = '0;
        cur_fwd  = 1'b0;
        s_mb_adr = '0;
        s_mb_wdt = '0;
        s_mb_val = 1'b0;
        bp_mode  = 0;
        m_vb.rdy = 1'b1;

        #3;
        check("rst_s_rdy", 32'(s_vb.rdy), 32'(0));
        check("rst_m_val", 32'(m_vb.val), 32'(0));
        check("rst_m_beat", 32'({m_vb.aux, m_vb.dat}), 32'(0));
        check("rst_rdt", 32'(s_mb_rdt), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        check("rdy_in_reset", 32'(s_vb.rdy), 32'(0));
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_reset", 32'(s_vb.rdy), 32'(1));
        expect_reg("width_rst", 8'h01, 16'd640);
        expect_reg("height_rst", 8'h02, 16'd480);
        expect_reg("ctrl_rst", 8'h00, 16'h0000);
        expect_reg("status_rst", 8'h03, 16'h0000);
        expect_reg("fcnt_rst", 8'h04, 16'h0000);
        expect_reg("unmapped", 8'h37, 16'h0000);

        // Disabled pass-through and one-cycle latency.
        send_beat(4'h2, 8'hA5, 1'b1);
        check("lat_val", 32'(m_vb.val), 32'(1));
        check("lat_beat", 32'({m_vb.aux, m_vb.dat}), 32'(12'h2A5));
        expect_reg("sts_disabled", 8'h03, 16'h0000);

        // Clean frame.
        mb_write(8'h00, 16'h0001);
        mb_write(8'h01, 16'd16);
        mb_write(8'h02, 16'd4);
        send_frame(16, 4);
        wait_drain();
        expect_reg("clean_status", 8'h03, 16'h0000);
        expect_reg("clean_fcnt", 8'h04, 16'd1);
        check("clean_error", 32'(error), 32'(0));
        check("clean_idle", 32'(dbg_state), 32'(0));

        // Backpressure with output ready toggling.
        bp_mode = 1;
        send_frame(16, 4);
        wait_drain();
        bp_mode = 0;
        expect_reg("bp_status", 8'h03, 16'h0000);
        expect_reg("bp_fcnt", 8'h04, 16'd2);

        // Beats before SOF are dropped.
        for (int i = 0; i < 5; i++) begin
            send_beat(4'($urandom_range(0, 15)) & 4'hE, 8'($urandom_range(0, 255)), 1'b0);
        end
        expect_reg("presof_status", 8'h03, 16'h0001);
        check("presof_error", 32'(error), 32'(1));
        send_frame(16, 4);
        wait_drain();
        expect_reg("presof_status2", 8'h03, 16'h0001);
        expect_reg("presof_fcnt", 8'h04, 16'd3);
        mb_write(8'h03, 16'h0001);
        expect_reg("w1c_status", 8'h03, 16'h0000);
        check("w1c_error", 32'(error), 32'(0));

        // Short and long lines.
        mb_write(8'h01, 16'd8);
        mb_write(8'h02, 16'd2);
        for (int c = 0; c < 6; c++) begin
            send_beat({2'b00, (c == 5), (c == 0)}, 8'(c), 1'b1);
        end
        expect_reg("short_line", 8'h03, 16'h0002);
        for (int c = 0; c < 8; c++) send_beat(4'h0, 8'(c + 16), 1'b1);
        expect_reg("no_early_long", 8'h03, 16'h0002);
        send_beat(4'h0, 8'h55, 1'b1);
        expect_reg("long_line", 8'h03, 16'h0006);
        send_beat(4'h6, 8'h66, 1'b1);
        expect_reg("long_eol", 8'h03, 16'h0006);
        expect_reg("line_fcnt", 8'h04, 16'd4);
        mb_write(8'h03, 16'h001F);
        expect_reg("clear_all", 8'h03, 16'h0000);

        // Row-count error, then SOF restart mid-line.
        mb_write(8'h01, 16'd4);
        mb_write(8'h02, 16'd4);
        send_frame(4, 3);
        expect_reg("row_count", 8'h03, 16'h0008);
        expect_reg("row_fcnt", 8'h04, 16'd5);
        mb_write(8'h03, 16'h0008);
        send_beat(4'h1, 8'h11, 1'b1);
        send_beat(4'h0, 8'h22, 1'b1);
        send_frame(4, 4);
        wait_drain();
        expect_reg("sof_restart", 8'h03, 16'h0010);
        expect_reg("restart_fcnt", 8'h04, 16'd6);
        mb_write(8'h03, 16'h0010);

        // Single beat carrying SOF, EOL and EOF on a 1x1 frame.
        mb_write(8'h01, 16'd1);
        mb_write(8'h02, 16'd1);
        send_frame(1, 1);
        expect_reg("one_pixel_status", 8'h03, 16'h0000);
        expect_reg("one_pixel_fcnt", 8'h04, 16'd7);
        mb_write(8'h04, 16'h1234);
        expect_reg("fcnt_clear", 8'h04, 16'h0000);

        // Disable mid-frame.
        mb_write(8'h01, 16'd4);
        mb_write(8'h02, 16'd4);
        send_beat(4'h1, 8'h31, 1'b1);
        send_beat(4'h0, 8'h32, 1'b1);
        check("active_mid", 32'(dbg_state), 32'(1));
        mb_write(8'h00, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            send_beat(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'b1);
        end
        wait_drain();
        check("disabled_idle", 32'(dbg_state), 32'(0));
        expect_reg("disabled_status", 8'h03, 16'h0000);
        expect_reg("disabled_fcnt", 8'h04, 16'h0000);

        // Reset while the buffer holds two stalled beats.
        mb_write(8'h01, 16'd100);
        expect_reg("width_written", 8'h01, 16'd100);
        bp_mode = 2;
        @(posedge clk);
        #1;
        send_beat(4'h3, 8'h77, 1'b1);
        send_beat(4'h8, 8'h88, 1'b1);
        check("full_rdy", 32'(s_vb.rdy), 32'(0));
        check("full_val", 32'(m_vb.val), 32'(1));
        @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        check("midrst_m_val", 32'(m_vb.val), 32'(0));
        check("midrst_m_beat", 32'({m_vb.aux, m_vb.dat}), 32'(0));
        check("midrst_s_rdy", 32'(s_vb.rdy), 32'(0));
        check("midrst_rdt", 32'(s_mb_rdt), 32'(0));
        check("midrst_error", 32'(error), 32'(0));
        @(posedge clk);
        #1;
        rstb    = 1'b1;
        bp_mode = 0;
        @(posedge clk);
        #1;
        expect_reg("width_after_rst", 8'h01, 16'd640);
        expect_reg("ctrl_after_rst", 8'h00, 16'h0000);

        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
